// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared control BRAM port.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_gnt_o;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_rvalid_o;

  logic              m1_req_i;
  logic              m1_gnt_o;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_rvalid_o;

  logic              bram_we_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [DATA_W-1:0] bram_dout_o;
  logic [DATA_W-1:0] bram_din_i;

  // Requesters plus the BRAM data source
  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output bram_din_i,
    input  m0_gnt_o, m0_rdata_o, m0_rvalid_o,
    input  m1_gnt_o, m1_rdata_o, m1_rvalid_o,
    input  bram_we_o, bram_addr_o, bram_dout_o
  );

  // Arbiter side
  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  bram_din_i,
    output m0_gnt_o, m0_rdata_o, m0_rvalid_o,
    output m1_gnt_o, m1_rdata_o, m1_rvalid_o,
    output bram_we_o, bram_addr_o, bram_dout_o
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing one BRAM port between two requesters,
// with tagged read-return routing that survives grant handovers.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  bram_port_arbiter_if.slave bus
);

  localparam int unsigned BURST_W = 8;
  localparam int unsigned TAG_D   = RD_LAT + 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d, burst_inc_c;
  logic               gnt0_q, gnt1_q;
  logic               acc_c, acc_sel_c;
  logic               acc_we_c;
  logic [ADDR_W-1:0]  acc_addr_c;
  logic [DATA_W-1:0]  acc_wdata_c;
  logic               bram_we_q;
  logic [ADDR_W-1:0]  bram_addr_q;
  logic [DATA_W-1:0]  bram_dout_q;
  logic [TAG_D-1:0]   tag_vld_q, tag_own_q;
  logic               rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]  rdata0_q, rdata1_q;

  // Burst count saturates at the limit so the limit check repeats on every accept
  assign burst_inc_c = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + BURST_W'(1);

  assign acc_we_c    = acc_sel_c ? bus.m1_we_i    : bus.m0_we_i;
  assign acc_addr_c  = acc_sel_c ? bus.m1_addr_i  : bus.m0_addr_i;
  assign acc_wdata_c = acc_sel_c ? bus.m1_wdata_i : bus.m0_wdata_i;

  // Next-state, round-robin and burst bookkeeping
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    acc_c     = 1'b0;
    acc_sel_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req_i && bus.m1_req_i) state_d = last_q ? GRANT0 : GRANT1;
        else if (bus.m0_req_i)            state_d = GRANT0;
        else if (bus.m1_req_i)            state_d = GRANT1;
      end
      GRANT0: begin
        if (!bus.m0_req_i) begin
          state_d = bus.m1_req_i ? GRANT1 : IDLE;
          last_d  = 1'b0;
        end else begin
          acc_c   = 1'b1;
          burst_d = burst_inc_c;
          if (burst_inc_c == BURST_MAX && bus.m1_req_i) begin
            state_d = GRANT1;
            last_d  = 1'b0;
          end
        end
      end
      GRANT1: begin
        acc_sel_c = 1'b1;
        if (!bus.m1_req_i) begin
          state_d = bus.m0_req_i ? GRANT0 : IDLE;
          last_d  = 1'b1;
        end else begin
          acc_c   = 1'b1;
          burst_d = burst_inc_c;
          if (burst_inc_c == BURST_MAX && bus.m0_req_i) begin
            state_d = GRANT0;
            last_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) burst_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_dout_q <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      gnt0_q    <= (state_d == GRANT0);
      gnt1_q    <= (state_d == GRANT1);
      bram_we_q <= acc_c & acc_we_c;
      if (acc_c) begin
        bram_addr_q <= acc_addr_c;
        bram_dout_q <= acc_wdata_c;
      end
      // Tag at index RD_LAT lines up with the BRAM data for that read
      tag_vld_q <= {tag_vld_q[TAG_D-2:0], acc_c & ~acc_we_c};
      tag_own_q <= {tag_own_q[TAG_D-2:0], acc_sel_c};
      rvalid0_q <= tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
      rvalid1_q <= tag_vld_q[RD_LAT] &  tag_own_q[RD_LAT];
      if (tag_vld_q[RD_LAT] && !tag_own_q[RD_LAT]) rdata0_q <= bus.bram_din_i;
      if (tag_vld_q[RD_LAT] &&  tag_own_q[RD_LAT]) rdata1_q <= bus.bram_din_i;
    end
  end

  assign bus.m0_gnt_o    = gnt0_q;
  assign bus.m1_gnt_o    = gnt1_q;
  assign bus.m0_rvalid_o = rvalid0_q;
  assign bus.m1_rvalid_o = rvalid1_q;
  assign bus.m0_rdata_o  = rdata0_q;
  assign bus.m1_rdata_o  = rdata1_q;
  assign bus.bram_we_o   = bram_we_q;
  assign bus.bram_addr_o = bram_addr_q;
  assign bus.bram_dout_o = bram_dout_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter against a transaction-level
// arbitration model and a behavioural BRAM.
module tb_bram_port_arbiter;

  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bif.slave)
  );

  function automatic logic [31:0] seed_word(input int i);
    case (i)
      1:       return 32'h0000_0005;
      4:       return 32'h0000_DEAD;
      default: return 32'hA000_0000 + 32'(i);
    endcase
  endfunction

  // Behavioural BRAM: RD_LAT-cycle registered read, reseeded under reset
  logic [31:0] mem [8];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 8; i++) mem[i] <= seed_word(i);
    else if (bif.bram_we_o) mem[bif.bram_addr_o[4:2]] <= bif.bram_dout_o;
    rd_pipe[0] <= mem[bif.bram_addr_o[4:2]];
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bif.bram_din_i = rd_pipe[RD_LAT-1];

  // Reference model state
  typedef struct { int due; int who; logic [31:0] data; } rd_t;
  rd_t         rq[$];
  logic [31:0] ref_mem [8];
  int          m_owner, m_last, m_burst, edge_n;
  logic        e_gnt0, e_gnt1, e_we, e_rv0, e_rv1;
  logic [31:0] e_addr, e_dout, e_rd0, e_rd1;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        d_r0, d_w0, d_r1, d_w1;
  logic [31:0] d_a0, d_d0, d_a1, d_d1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_burst = 0;
    e_gnt0 = 0; e_gnt1 = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0;
    e_addr = 0; e_dout = 0; e_rd0 = 0; e_rd1 = 0;
    rq.delete();
    for (int i = 0; i < 8; i++) ref_mem[i] = seed_word(i);
  endtask

  // One clock edge of the arbitration rules, given the inputs present at that edge
  task automatic model_edge();
    int nxt, acc;
    logic rx, ry, aw;
    logic [31:0] aa, ad;
    rd_t t;
    edge_n++;
    e_rv0 = 0; e_rv1 = 0;
    while (rq.size() > 0 && rq[0].due == edge_n) begin
      t = rq.pop_front();
      if (t.who == 0) begin e_rv0 = 1; e_rd0 = t.data; end
      else            begin e_rv1 = 1; e_rd1 = t.data; end
    end
    acc = -1; nxt = m_owner;
    if (m_owner < 0) begin
      if (d_r0 && d_r1) nxt = (m_last == 0) ? 1 : 0;
      else if (d_r0)    nxt = 0;
      else if (d_r1)    nxt = 1;
    end else begin
      rx = (m_owner == 0) ? d_r0 : d_r1;
      ry = (m_owner == 0) ? d_r1 : d_r0;
      if (!rx) begin
        nxt = ry ? 1 - m_owner : -1;
        m_last = m_owner;
      end else begin
        acc = m_owner;
        if (m_burst < int'(MAX_BURST)) m_burst++;
        if (m_burst == int'(MAX_BURST) && ry) begin
          nxt = 1 - m_owner;
          m_last = m_owner;
        end
      end
    end
    if (nxt != m_owner) m_burst = 0;
    m_owner = nxt;
    e_gnt0 = (nxt == 0);
    e_gnt1 = (nxt == 1);
    e_we = 0;
    if (acc >= 0) begin
      aw = (acc == 1) ? d_w1 : d_w0;
      aa = (acc == 1) ? d_a1 : d_a0;
      ad = (acc == 1) ? d_d1 : d_d0;
      e_we = aw; e_addr = aa; e_dout = ad;
      if (aw) ref_mem[aa[4:2]] = ad;
      else rq.push_back('{due: edge_n + int'(RD_LAT) + 1, who: acc, data: ref_mem[aa[4:2]]});
    end
  endtask

  task automatic compare_all();
    check("gnt0",      32'(bif.m0_gnt_o),    32'(e_gnt0));
    check("gnt1",      32'(bif.m1_gnt_o),    32'(e_gnt1));
    check("bram_we",   32'(bif.bram_we_o),   32'(e_we));
    check("bram_addr", bif.bram_addr_o,      e_addr);
    check("bram_dout", bif.bram_dout_o,      e_dout);
    check("rvalid0",   32'(bif.m0_rvalid_o), 32'(e_rv0));
    check("rvalid1",   32'(bif.m1_rvalid_o), 32'(e_rv1));
    check("rdata0",    bif.m0_rdata_o,       e_rd0);
    check("rdata1",    bif.m1_rdata_o,       e_rd1);
  endtask

  // Called just after a falling edge: drive, predict, clock, compare
  task automatic cycle();
    bif.m0_req_i = d_r0; bif.m0_we_i = d_w0; bif.m0_addr_i = d_a0; bif.m0_wdata_i = d_d0;
    bif.m1_req_i = d_r1; bif.m1_we_i = d_w1; bif.m1_addr_i = d_a1; bif.m1_wdata_i = d_d1;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    d_r0 = r; d_w0 = w; d_a0 = a; d_d0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    d_r1 = r; d_w1 = w; d_a1 = a; d_d1 = d;
  endtask

  task automatic rand_acc(input int who);
    logic        w;
    logic [31:0] a, d;
    w = 1'($urandom_range(0, 1));
    a = 32'($urandom_range(0, 5)) << 2;
    d = $urandom;
    if (who == 0) set0(1'b1, w, a, d);
    else          set1(1'b1, w, a, d);
  endtask

  initial begin
    int we_cnt;
    edge_n = 0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    model_reset();
    cycle_inputs_idle: begin
      bif.m0_req_i = 0; bif.m0_we_i = 0; bif.m0_addr_i = 0; bif.m0_wdata_i = 0;
      bif.m1_req_i = 0; bif.m1_we_i = 0; bif.m1_addr_i = 0; bif.m1_wdata_i = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // First tie after reset goes to requester 0; handover to 1 is direct
    set0(1, 1, 32'h8, 32'h1111);
    set1(1, 1, 32'h14, 32'h2222);
    cycle();
    check("tie1_gnt0", 32'(bif.m0_gnt_o), 32'd1);
    cycle();
    set0(0, 0, 0, 0);
    cycle();
    check("tie1_gnt1_direct", 32'(bif.m1_gnt_o), 32'd1);
    cycle();
    set1(0, 0, 0, 0);
    repeat (2) cycle();

    // Single requester read of 0x4
    set0(1, 0, 32'h4, 0);
    cycle();
    check("rd_gnt_latency", 32'(bif.m0_gnt_o), 32'd1);
    cycle();
    check("rd_bram_addr", bif.bram_addr_o, 32'h4);
    set0(0, 0, 32'h4, 0);
    repeat (3) cycle();
    check("rd_rvalid0", 32'(bif.m0_rvalid_o), 32'd1);
    check("rd_rdata0", bif.m0_rdata_o, 32'h5);
    repeat (2) cycle();

    // Second tie: requester 0 was served last, so requester 1 wins
    set0(1, 0, 32'h0, 0);
    set1(1, 0, 32'h4, 0);
    cycle();
    check("tie2_gnt1", 32'(bif.m1_gnt_o), 32'd1);
    set1(0, 0, 0, 0);
    cycle();
    set0(0, 0, 0, 0);
    repeat (6) cycle();

    // Handover with a read in flight
    set0(1, 0, 32'h10, 0);
    cycle();
    set1(1, 1, 32'h0, 32'h0);
    cycle();
    set0(0, 0, 0, 0);
    cycle();
    cycle();
    set1(0, 0, 0, 0);
    cycle();
    check("ho_rvalid0", 32'(bif.m0_rvalid_o), 32'd1);
    check("ho_rdata0", bif.m0_rdata_o, 32'hDEAD);
    check("ho_rvalid1", 32'(bif.m1_rvalid_o), 32'd0);
    repeat (3) cycle();

    // Burst limit with competition
    set0(1, 1, 32'hC, 32'hC0C0_0001);
    cycle();
    set1(1, 0, 32'h14, 0);
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bif.bram_we_o) we_cnt++;
      if (i == 3) begin
        check("burst_gnt0_drop", 32'(bif.m0_gnt_o), 32'd0);
        check("burst_gnt1_rise", 32'(bif.m1_gnt_o), 32'd1);
      end
    end
    check("burst_we_count", 32'(we_cnt), 32'd4);
    set1(0, 0, 0, 0);
    repeat (2) cycle();
    set0(0, 0, 0, 0);
    repeat (5) cycle();

    // Burst limit without competition: grant is kept
    set0(1, 1, 32'hC, 32'hC0C0_0002);
    repeat (12) cycle();
    check("solo_keeps_gnt0", 32'(bif.m0_gnt_o), 32'd1);
    set0(0, 0, 0, 0);
    repeat (2) cycle();

    // Randomized traffic, requesters hold their access until granted
    for (int n = 0; n < 600; n++) begin
      if (d_r0) begin
        if (m_owner == 0) begin
          if ($urandom_range(0, 7) == 0) d_r0 = 1'b0;
          else rand_acc(0);
        end
      end else if ($urandom_range(0, 3) == 0) rand_acc(0);
      if (d_r1) begin
        if (m_owner == 1) begin
          if ($urandom_range(0, 7) == 0) d_r1 = 1'b0;
          else rand_acc(1);
        end
      end else if ($urandom_range(0, 3) == 0) rand_acc(1);
      cycle();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (8) cycle();

    // Reset between a read's accept and its return
    set0(1, 0, 32'h4, 0);
    cycle();
    cycle();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_gnt0", 32'(bif.m0_gnt_o), 32'd0);
    check("rst_bram_addr", bif.bram_addr_o, 32'h0);
    check("rst_bram_we", 32'(bif.bram_we_o), 32'd0);
    check("rst_rvalid0", 32'(bif.m0_rvalid_o), 32'd0);
    check("rst_rdata0", bif.m0_rdata_o, 32'h0);
    model_reset();
    set0(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter for the single 32-bit port of the shared control BRAM. The BRAM holds the command mailbox at 0x0, the enable/reset masks at 0x4/0x8 and the counter snapshots at 0xC–0x14. The block lets the counter management FSM (requester 0) and a second master, such as a snapshot scheduler or debug port (requester 1), share that port without collisions. It issues grants round-robin with a bounded burst length, and routes read data back to whichever requester issued each read, even across grant handovers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2
- MAX_BURST, 8, maximum consecutive accepted accesses while the other requester waits; legal range 1..255

- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m0_req_i  in  1  requester 0 wants the port; held high for its whole session
- m0_gnt_o  out  1  requester 0 owns the port (registered)
- m0_we_i  in  1  requester 0 write enable for the current access
- m0_addr_i  in  ADDR_W  requester 0 byte address
- m0_wdata_i  in  DATA_W  requester 0 write data
- m0_rdata_o  out  DATA_W  read data returned to requester 0
- m0_rvalid_o  out  1  one-cycle strobe qualifying m0_rdata_o
- m1_req_i, m1_gnt_o, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_rvalid_o: same as requester 0, for requester 1
- bram_we_o  out  1  BRAM write enable
- bram_addr_o  out  ADDR_W  BRAM address
- bram_dout_o  out  DATA_W  BRAM write data
- bram_din_i  in  DATA_W  BRAM read data

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- Grants are registered: mX_gnt_o = (state == GRANTX). Grants are mutually exclusive, and both are low in IDLE.
- last_q records the last-served requester.
  - Reset value of last_q is 1, so requester 0 wins the first tie.
- IDLE transitions:
  - Exactly one requester asserts req: go to that requester's GRANT state.
  - Both requesters assert req: go to the GRANT state of the requester ≠ last_q.
  - No requester asserts req: stay in IDLE.
- Accept rule: an access is accepted on an edge where mX_req_i & mX_gnt_o.
  - At that edge bram_we_o, bram_addr_o and bram_dout_o load mX_we_i, mX_addr_i and mX_wdata_i.
  - On edges with no accepted access, bram_we_o loads 0 and bram_addr_o and bram_dout_o hold their values.
- burst_q is an 8-bit count of accesses accepted in the current grant. It clears on every state change.
- Leaving GRANTX (X is the owner, Y is the other requester):
  - Owner drops req: go to GRANTY if mY_req_i is high, else IDLE. No access is accepted on that edge.
  - Burst limit: if the accept edge brings burst_q to MAX_BURST and mY_req_i is high, go to GRANTY on that same edge.
  - Burst limit without competition: if mY_req_i is low at the limit, stay in GRANTX and let burst_q saturate. The check is repeated every accept.
  - On any exit, last_q is set to X.
- Read return path:
  - Each accepted read (we = 0) pushes a tag {valid, owner} into a shift register of depth RD_LAT+1.
  - When the tag emerges, bram_din_i is registered into mOwner_rdata_o and mOwner_rvalid_o pulses for one cycle.
  - Writes push invalid tags.
  - Routing follows the tag, not the current grant, so reads in flight at a handover go to their issuer.
- mX_rdata_o holds its last value when rvalid is low.

## Timing
- Values after reset: all gnt low, all rvalid low, all rdata 0, bram_we_o 0, bram_addr_o 0, bram_dout_o 0, state IDLE, burst_q 0, tag pipe cleared.
- Reset during operation clears everything immediately. In-flight reads are discarded and produce no rvalid.
- Request to grant: the request is sampled high in IDLE at edge E, and gnt_o goes high after E. Minimum latency is 1 cycle.
- Access to BRAM: an access accepted at edge E is presented on the bram_* outputs during cycle E+1.
- Read latency: rvalid_o is high in the cycle after edge E+RD_LAT+1, i.e. RD_LAT+2 cycles from the accept edge.
- Throughput: one access per cycle while granted.
- Handover cost:
  - Direct switch (GRANT0→GRANT1 or the reverse): one cycle with no access.
  - Via IDLE: at least two cycles with no access.
- A requester must hold we, addr and wdata stable while req is high and gnt is low. The arbiter does not buffer requests.

## Test plan
- Single requester read: reset; m0 holds req, reads 0x4 (BRAM model returns 0x5), then drops req.
  - gnt0 high 1 cycle after req.
  - bram_addr_o = 0x4 one cycle after accept.
  - m0_rvalid_o pulses with m0_rdata_o = 0x5 at RD_LAT+2 cycles.
  - m1_rvalid_o stays 0.
- Tie after reset: m0 and m1 raise req on the same cycle. Required response: m0 granted first. After m0 releases, m1 is granted with a one-cycle gap. On the next tie, m1 wins.
- Burst limit: MAX_BURST = 4; m0 issues continuous writes to 0xC while m1 requests.
  - Exactly 4 bram_we_o pulses for m0.
  - gnt0 drops and gnt1 rises on the edge of the 4th accept.
  - Same test with m1 idle: m0 keeps the grant indefinitely.
- Handover with a read in flight: RD_LAT = 2; m0 reads 0x10 (model returns 0xDEAD) and drops req on the next cycle; m1 immediately writes 0x0 ← 0. Required response: 0xDEAD appears only on m0_rdata_o with m0_rvalid_o; m1_rvalid_o stays 0.
- Reset during operation: assert rst_i between the accept edge of a read and its return. Required response: all outputs go to their reset values asynchronously, no rvalid fires after reset, and the FSM returns to IDLE.
